// File: rtl/raccoon_sprite_draw.sv
// raccoon_sprite_draw: renders the 32x32 raccoon sprite into the VGA pixel
// stream from a frame-latched position, with a 2-cycle ROM fetch pipeline.
//
// Ports:
//   i_Clk, i_Rst_L                pixel clock, async active-low reset
//   i_Raccoon_X/Y                 sprite top-left from the controller
//   i_Facing_Left, i_Moving       mirror flag, walk-animation enable
//   i_Frame_Start                 one-cycle pulse at vertical blank start
//   i_Col_Count, i_Row_Count      current scan position
//   o_Rom_Addr, i_Rom_Data        sprite ROM address / texel (0 = clear)
//   o_Draw, o_Color_Idx           registered opaque flag and palette index
module raccoon_sprite_draw #(
    parameter int c_PLAYER_WIDTH  = 32,
    parameter int c_PLAYER_HEIGHT = 32,
    parameter int c_GAME_WIDTH    = 640,
    parameter int c_GAME_HEIGHT   = 480,
    parameter int c_ANIM_FRAMES   = 8
) (
    input  logic        i_Clk,
    input  logic        i_Rst_L,
    input  logic [9:0]  i_Raccoon_X,
    input  logic [9:0]  i_Raccoon_Y,
    input  logic        i_Facing_Left,
    input  logic        i_Moving,
    input  logic        i_Frame_Start,
    input  logic [9:0]  i_Col_Count,
    input  logic [9:0]  i_Row_Count,
    output logic [10:0] o_Rom_Addr,
    input  logic [3:0]  i_Rom_Data,
    output logic        o_Draw,
    output logic [3:0]  o_Color_Idx
);

    localparam int c_CNT_W =
        (c_ANIM_FRAMES > 1) ? $clog2(c_ANIM_FRAMES) : 1;

    localparam logic [9:0] c_X_RST =
        10'((c_GAME_WIDTH - c_PLAYER_WIDTH) / 2);
    localparam logic [9:0] c_Y_RST =
        10'((c_GAME_HEIGHT - c_PLAYER_HEIGHT) / 2);
    localparam logic [c_CNT_W-1:0] c_CNT_LAST =
        c_CNT_W'(c_ANIM_FRAMES - 1);

    logic [9:0]         x_lat;
    logic [9:0]         y_lat;
    logic               facing_lat;
    logic [c_CNT_W-1:0] anim_cnt;
    logic               anim_bit;
    logic               v1;

    logic [10:0] dx;
    logic [10:0] dy;
    logic        in_x;
    logic        in_y;
    logic        hit;
    logic [4:0]  col_off;
    logic [4:0]  row_off;
    logic        draw_next;

    // Position, facing and animation change only at frame start so a
    // mid-frame controller update cannot tear the sprite.
    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            x_lat      <= c_X_RST;
            y_lat      <= c_Y_RST;
            facing_lat <= 1'b0;
            anim_cnt   <= '0;
            anim_bit   <= 1'b0;
        end else if (i_Frame_Start) begin
            x_lat      <= i_Raccoon_X;
            y_lat      <= i_Raccoon_Y;
            facing_lat <= i_Facing_Left;
            if (!i_Moving) begin
                anim_cnt <= '0;
                anim_bit <= 1'b0;
            end else if (anim_cnt == c_CNT_LAST) begin
                anim_cnt <= '0;
                anim_bit <= ~anim_bit;
            end else begin
                anim_cnt <= anim_cnt + 1'b1;
            end
        end
    end

    // 11-bit differences: bit 10 set means the scan is left of / above the
    // sprite. With that bit clear, d < size is the same test as
    // scan < pos + size done in 11 bits, so no wrap near 1023.
    always_comb begin
        dx      = {1'b0, i_Col_Count} - {1'b0, x_lat};
        dy      = {1'b0, i_Row_Count} - {1'b0, y_lat};
        in_x    = !dx[10] && (dx < 11'(c_PLAYER_WIDTH))
                  && ({1'b0, i_Col_Count} < 11'(c_GAME_WIDTH));
        in_y    = !dy[10] && (dy < 11'(c_PLAYER_HEIGHT))
                  && ({1'b0, i_Row_Count} < 11'(c_GAME_HEIGHT));
        hit     = in_x && in_y;
        row_off = dy[4:0];
        col_off = facing_lat ? (5'(c_PLAYER_WIDTH - 1) - dx[4:0])
                             : dx[4:0];
    end

    // Stage 0: address is held on a miss so the ROM sees no needless toggles.
    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            o_Rom_Addr <= '0;
            v1         <= 1'b0;
        end else begin
            v1 <= hit;
            if (hit) begin
                o_Rom_Addr <= {anim_bit, row_off, col_off};
            end
        end
    end

    assign draw_next = v1 && (i_Rom_Data != 4'd0);

    // Stage 1: texel value 0 is the transparent key.
    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            o_Draw      <= 1'b0;
            o_Color_Idx <= 4'd0;
        end else begin
            o_Draw      <= draw_next;
            o_Color_Idx <= draw_next ? i_Rom_Data : 4'd0;
        end
    end

endmodule

// File: doc/raccoon_sprite_draw.md
Name: raccoon_sprite_draw

Overview:
- Consumes the raccoon X/Y position produced by the raccoon controller and renders the 32x32 raccoon sprite into the VGA pixel stream.
- Latches position, facing direction and animation state once per frame.
- Hit-tests the scan position, fetches sprite texels from an external synchronous ROM, and emits a registered draw-enable plus colour index for the pixel mux.

Parameters:
- c_PLAYER_WIDTH, 32, sprite width in pixels (power of 2, 5-bit offset).
- c_PLAYER_HEIGHT, 32, sprite height in pixels (power of 2, 5-bit offset).
- c_GAME_WIDTH, 640, visible columns; pixels at col >= this are never drawn.
- c_GAME_HEIGHT, 480, visible rows; pixels at row >= this are never drawn.
- c_ANIM_FRAMES, 8, video frames per walk-animation step.

Ports:
- i_Clk  input  1  pixel clock
- i_Rst_L  input  1  asynchronous active-low reset
- i_Raccoon_X  input  10  sprite top-left X from the controller
- i_Raccoon_Y  input  10  sprite top-left Y from the controller
- i_Facing_Left  input  1  1 = mirror sprite horizontally
- i_Moving  input  1  1 = any direction button held
- i_Frame_Start  input  1  one-cycle pulse at the start of the vertical blank
- i_Col_Count  input  10  current scan column
- i_Row_Count  input  10  current scan row
- o_Rom_Addr  output  11  sprite ROM address {anim, row_off[4:0], col_off[4:0]}
- i_Rom_Data  input  4  ROM texel; valid 1 cycle after o_Rom_Addr; 0 = transparent
- o_Draw  output  1  1 = raccoon pixel opaque at this pipeline slot
- o_Color_Idx  output  4  palette index, valid when o_Draw = 1, else 0

Behaviour:
- Reset (i_Rst_L low, asynchronous): all regs clear immediately.
  - Latched X = (c_GAME_WIDTH-c_PLAYER_WIDTH)/2 = 304; latched Y = (c_GAME_HEIGHT-c_PLAYER_HEIGHT)/2 = 224.
  - Latched facing = 0; anim counter = 0; anim bit = 0.
  - o_Rom_Addr = 0, o_Draw = 0, o_Color_Idx = 0; pipeline valid bits = 0.
- Frame latch: on the cycle i_Frame_Start = 1, capture i_Raccoon_X, i_Raccoon_Y and i_Facing_Left. These values are used for the whole following frame, so input changes mid-frame never tear the sprite.
- Animation (updated on i_Frame_Start only):
  - i_Moving = 1: counter increments. At c_ANIM_FRAMES-1 the counter wraps to 0 and the anim bit toggles.
  - i_Moving = 0: counter and anim bit go to 0.
- Stage 0 (registered; inputs are col/row of cycle N):
  - dx = col - X, dy = row - Y, computed in 11-bit unsigned with the sign bit checked.
  - hit = (col >= X) and (col < X+W) and (row >= Y) and (row < Y+H) and (col < c_GAME_WIDTH) and (row < c_GAME_HEIGHT).
  - X+W and Y+H are computed in 11 bits so no wrap occurs at X up to 1023.
  - col_off = facing ? (W-1-dx[4:0]) : dx[4:0]; row_off = dy[4:0].
  - o_Rom_Addr <= {anim, row_off, col_off} when hit, else it holds its previous value. v1 <= hit.
- Stage 1 (cycle N+2): o_Draw <= v1 and (i_Rom_Data != 0); o_Color_Idx <= o_Draw_next ? i_Rom_Data : 0.
- Latency: exactly 2 cycles from col/row to o_Draw/o_Color_Idx. The pixel mux delays the background by 2 to match.
- Frame start in the same cycle as a hit: stage 0 uses the old latched position; the new position applies from the next cycle.
- Partial off-screen sprite (X > 608 or Y > 448): drawn up to the screen edge, clipped by the c_GAME_* checks.
- Reset mid-frame: outputs drop to 0 asynchronously. After release, drawing uses the centre position until the next i_Frame_Start.

Test Plan:
- Reset, then drive frame_start with X=100, Y=50, facing 0, ROM returns 5 everywhere, scan row 50 cols 98..133 -> o_Draw = 1 exactly for cols 100..131 (2 cycles late), o_Color_Idx = 5, o_Rom_Addr = 0..31 ascending.
- Same setup with facing = 1 -> o_Rom_Addr[4:0] descends 31..0 across cols 100..131.
- ROM returns 0 at address 3 -> o_Draw = 0 and o_Color_Idx = 0 only on the slot for col 103.
- Latch X=620, Y=470 -> draw only at cols 620..639 and rows 470..479; nothing at col 640+ or row 480+.
- Change i_Raccoon_X from 100 to 200 mid-frame -> drawing stays at 100 until the next i_Frame_Start, then moves to 200.
- i_Moving=1 for 16 frame_starts with c_ANIM_FRAMES=8 -> anim bit (o_Rom_Addr[10]) toggles after the 8th and 16th pulses. One pulse with i_Moving=0 -> anim bit = 0.
